// File: rtl/pipeline_sequencer.sv
// Pipeline sequencing controller: latch enables/flushes, PC enable,
// dcache request qualification, halt and saturating perf counters.
module pipeline_sequencer #(
   parameter int REGBITS = 5,
   parameter int CNTW    = 16
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               ihit,
   input  logic               dhit,
   input  logic               mem_dren,
   input  logic               mem_dwen,
   input  logic               mem_branch_taken,
   input  logic               ex_memread,
   input  logic [REGBITS-1:0] ex_wsel,
   input  logic [REGBITS-1:0] id_rs,
   input  logic [REGBITS-1:0] id_rt,
   input  logic               wb_halt,
   output logic               pc_en,
   output logic               ifid_en,
   output logic               idex_en,
   output logic               exm_en,
   output logic               mwb_en,
   output logic               ifid_flush,
   output logic               idex_flush,
   output logic               exm_flush,
   output logic               mwb_flush,
   output logic               dmem_req,
   output logic               load_capture,
   output logic               halt,
   output logic [CNTW-1:0]    stall_cnt,
   output logic [CNTW-1:0]    flush_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DDONE  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] stall_q, stall_d;
   logic [CNTW-1:0] flush_q, flush_d;

   logic mem_req, run, advance, load_use;
   logic stall_inc, flush_inc;

   assign mem_req  = mem_dren | mem_dwen;
   assign run      = (state_q == RUN);
   assign advance  = (state_q != HALTED) & ihit
                   & (!mem_req | dhit | (state_q == DDONE));
   assign load_use = ex_memread & (ex_wsel != '0)
                   & ((ex_wsel == id_rs) | (ex_wsel == id_rt));

   always_comb begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exm_en       = 1'b0;
      mwb_en       = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exm_flush    = 1'b0;
      mwb_flush    = 1'b0;
      dmem_req     = 1'b0;
      load_capture = 1'b0;
      if (nRST) begin
         dmem_req     = mem_req & run;
         load_capture = mem_dren & dhit & run;
         // wb_halt freezes everything, so it outranks a taken branch
         if (advance && !wb_halt) begin
            if (mem_branch_taken) begin
               pc_en      = 1'b1;
               ifid_en    = 1'b1;
               idex_en    = 1'b1;
               exm_en     = 1'b1;
               mwb_en     = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               exm_flush  = 1'b1;
            end else if (load_use) begin
               idex_en    = 1'b1;
               idex_flush = 1'b1;
               exm_en     = 1'b1;
               mwb_en     = 1'b1;
            end else begin
               pc_en   = 1'b1;
               ifid_en = 1'b1;
               idex_en = 1'b1;
               exm_en  = 1'b1;
               mwb_en  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q != HALTED) begin
         if (wb_halt)
            state_d = HALTED;
         else if (state_q == DDONE) begin
            if (ihit) state_d = RUN;
         end else if (mem_req && dhit && !ihit)
            state_d = DDONE;
      end
   end

   assign stall_inc = (state_q != HALTED)
                    & (!advance
                       | (load_use & !mem_branch_taken & !wb_halt));
   assign flush_inc = advance & mem_branch_taken & !wb_halt;

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (stall_inc && stall_q != '1) stall_d = stall_q + 1'b1;
      if (flush_inc && flush_q != '1) flush_d = flush_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign halt      = (state_q == HALTED);
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a behavioural
// reference model compared on every falling clock edge.
module tb_pipeline_sequencer;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       ihit = 0, dhit = 0, mem_dren = 0, mem_dwen = 0;
   logic       mem_branch_taken = 0, ex_memread = 0, wb_halt = 0;
   logic [4:0] ex_wsel = 0, id_rs = 0, id_rt = 0;
   logic       pc_en, ifid_en, idex_en, exm_en, mwb_en;
   logic       ifid_flush, idex_flush, exm_flush, mwb_flush;
   logic       dmem_req, load_capture, halt;
   logic [15:0] stall_cnt, flush_cnt;

   int passed = 0;
   int total  = 0;

   // model state: halted flag, waiting-for-ihit flag, counters
   logic        m_halt = 0, m_wait = 0;
   int          m_stall = 0, m_flush = 0;

   always #5 CLK = ~CLK;

   pipeline_sequencer dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dren(mem_dren), .mem_dwen(mem_dwen),
      .mem_branch_taken(mem_branch_taken),
      .ex_memread(ex_memread), .ex_wsel(ex_wsel),
      .id_rs(id_rs), .id_rt(id_rt), .wb_halt(wb_halt),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exm_en(exm_en), .mwb_en(mwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exm_flush(exm_flush), .mwb_flush(mwb_flush),
      .dmem_req(dmem_req), .load_capture(load_capture),
      .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   logic [10:0] ctrl;
   assign ctrl = {pc_en, ifid_en, idex_en, exm_en, mwb_en,
                  ifid_flush, idex_flush, exm_flush, mwb_flush,
                  dmem_req, load_capture};

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    nm, got, exp, $time);
   endtask

   function automatic logic m_adv();
      logic mreq;
      mreq = mem_dren | mem_dwen;
      return !m_halt && ihit && (!mreq || dhit || m_wait);
   endfunction

   function automatic logic m_lu();
      return ex_memread && ex_wsel != 0
             && (ex_wsel == id_rs || ex_wsel == id_rt);
   endfunction

   // {pc, en x4, flush x4, dmem_req, load_capture}
   function automatic logic [10:0] exp_ctrl();
      logic [10:0] v;
      logic        mreq;
      v = '0;
      if (!nRST || m_halt) return v;
      mreq = mem_dren | mem_dwen;
      v[1] = mreq && !m_wait;
      v[0] = mem_dren && dhit && !m_wait;
      if (m_adv() && !wb_halt) begin
         if (mem_branch_taken)  v[10:2] = 9'b11111_1110;
         else if (m_lu())       v[10:2] = 9'b00111_0100;
         else                   v[10:2] = 9'b11111_0000;
      end
      return v;
   endfunction

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_halt = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      end else if (!m_halt) begin
         if (!m_adv() || (m_lu() && !mem_branch_taken && !wb_halt))
            m_stall = (m_stall == 16'hFFFF) ? m_stall : m_stall + 1;
         if (m_adv() && mem_branch_taken && !wb_halt)
            m_flush = (m_flush == 16'hFFFF) ? m_flush : m_flush + 1;
         if (wb_halt)     m_halt = 1;
         else if (m_wait) m_wait = !ihit;
         else m_wait = (mem_dren | mem_dwen) && dhit && !ihit;
      end
   end

   always @(negedge CLK) begin
      check("ctrl", {21'd0, ctrl}, {21'd0, exp_ctrl()});
      check("halt", {31'd0, halt}, {31'd0, m_halt});
      check("stall_cnt", {16'd0, stall_cnt}, m_stall);
      check("flush_cnt", {16'd0, flush_cnt}, m_flush);
   end

   task automatic step(input logic ih, dh, dr, dw, br, emr,
                       input logic [4:0] ew, rs, rt,
                       input logic wh);
      @(posedge CLK); #1;
      ihit = ih; dhit = dh; mem_dren = dr; mem_dwen = dw;
      mem_branch_taken = br; ex_memread = emr;
      ex_wsel = ew; id_rs = rs; id_rt = rt; wb_halt = wh;
   endtask

   task automatic idle(input logic ih);
      step(ih, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      idle(1);
      #1 check("rst_forced", {21'd0, ctrl}, 0);
      check("rst_cnt", {stall_cnt, flush_cnt}, 0);
      idle(1);
      nRST = 1;
      #1 check("run_ctrl", {21'd0, ctrl}, 32'b11111_0000_00);
      repeat (10) idle(1);
      check("run_stall0", {16'd0, stall_cnt}, 0);
      check("run_flush0", {16'd0, flush_cnt}, 0);

      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      #1 check("lcap_c2", {31'd0, load_capture}, 1);
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #1 check("dreq_c3", {31'd0, dmem_req}, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      #1 check("dreq_c4", {30'd0, dmem_req, load_capture}, 0);
      check("adv_c4", {31'd0, pc_en}, 1);
      idle(1);
      check("mem_stall3", {16'd0, stall_cnt}, 3);

      step(1, 0, 0, 0, 0, 1, 5, 0, 5, 0);
      #1 check("lu_ctrl", {21'd0, ctrl}, 32'b00111_0100_00);
      step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      #1 check("lu_r0", {21'd0, ctrl}, 32'b11111_0000_00);
      idle(1);
      check("lu_stall4", {16'd0, stall_cnt}, 4);

      step(1, 0, 0, 0, 1, 1, 5, 5, 0, 0);
      #1 check("br_ctrl", {21'd0, ctrl}, 32'b11111_1110_00);
      idle(1);
      check("br_flush1", {16'd0, flush_cnt}, 1);
      check("br_stall4", {16'd0, stall_cnt}, 4);

      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1 check("hlt_ctrl", {21'd0, ctrl}, 0);
      check("hlt_pre", {31'd0, halt}, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      #1 check("hlt_set", {31'd0, halt}, 1);
      check("hlt_frozen", {21'd0, ctrl}, 0);
      repeat (3) step(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
      check("hlt_stall4", {16'd0, stall_cnt}, 4);
      idle(0);
      nRST = 0;
      idle(0);
      nRST = 1;
      #1 check("rst_halt", {31'd0, halt}, 0);
      check("rst_cnts", {stall_cnt, flush_cnt}, 0);

      step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      #1 check("dd_enter", {31'd0, dmem_req}, 0);
      nRST = 0;
      idle(0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      nRST = 1;
      #1 check("dd_discard", {31'd0, dmem_req}, 1);

      nRST = 0;
      idle(0);
      nRST = 1;
      repeat (65540) idle(0);
      check("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
      idle(0);
      check("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);

      @(posedge CLK);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central sequencing controller for the five-stage pipelined datapath. It generates the per-latch enable and flush controls for the IF/ID, ID/EX, EX/M and M/WB pipeline registers and the PC enable. It sequences the pipeline around:
- instruction and data cache hits;
- load-use hazards;
- taken branches resolved in M;
- the final HALT.

It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- REGBITS, 5, register-select width.
- CNTW, 16, performance counter width.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- mem_dren, mem_dwen  in  1 each  instruction in M stage requests data read / write.
- mem_branch_taken  in  1  branch/jump in M stage resolved taken.
- ex_memread  in  1  instruction in EX stage is a load.
- ex_wsel  in  REGBITS  destination register of EX-stage instruction.
- id_rs, id_rt  in  REGBITS each  source registers of ID-stage instruction.
- wb_halt  in  1  HALT present at M/WB output.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exm_en, mwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exm_flush, mwb_flush  out  1 each  synchronous latch clears, sampled on the same edge as the enables.
- dmem_req  out  1  qualified data request to dcache.
- load_capture  out  1  pulse: load data valid now; must be held by the M/WB input register.
- halt  out  1  processor halted (sticky).
- stall_cnt, flush_cnt  out  CNTW each  performance counters.

## Operation
- State register with three states:
  - RUN: normal operation.
  - DDONE: data access finished, awaiting ihit.
  - HALTED: processor stopped.
- mem_req = mem_dren | mem_dwen.
- dmem_req = mem_req & (state==RUN). It is held low in DDONE so the dcache does not reissue a completed access.
- load_capture = mem_dren & dhit & (state==RUN).
- advance = (state!=HALTED) & ihit & (!mem_req | dhit | state==DDONE).
- Transitions:
  - RUN -> DDONE when mem_req & dhit & !ihit.
  - DDONE -> RUN when ihit.
  - any state -> HALTED when wb_halt; HALTED is left only by reset.
- load_use = ex_memread & (ex_wsel!=0) & ((ex_wsel==id_rs) | (ex_wsel==id_rt)).
- Per-cycle outputs when advance, in priority order:
  1. wb_halt: all enables 0, all flushes 0.
  2. mem_branch_taken: pc_en=1 (PC loads target), all enables 1, ifid_flush=idex_flush=exm_flush=1, mwb_flush=0.
  3. load_use: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1 (bubble), exm_en=mwb_en=1.
  4. otherwise: pc_en and all enables 1, no flushes.
- When !advance: all enables 0, all flushes 0, pc_en 0.
- In HALTED: all enables, flushes, pc_en and dmem_req are 0; halt=1.
- Counters (both saturate at all-ones, never wrap):
  - stall_cnt +1 on every non-HALTED cycle with !advance, or with advance & load_use & !mem_branch_taken & !wb_halt.
  - flush_cnt +1 on each advance with mem_branch_taken & !wb_halt.
- Reset: state=RUN, halt=0, stall_cnt=0, flush_cnt=0.
  - While nRST is low, all enables, flushes, pc_en, dmem_req and load_capture are forced to 0.
  - Reset mid-DDONE returns to RUN and discards the pending completion.

## Timing
- All control outputs are combinational from the current state and inputs; state and counters are registered.
- Load-use costs exactly 1 bubble; the dependent instruction advances on the next advance cycle with no repeated stall, because the load has moved to M.
- A taken branch squashes 3 wrong-path slots; the target instruction enters IF/ID 1 advance after the flush.
- halt asserts the cycle after wb_halt is sampled.
- Simultaneous dhit & ihit in RUN with mem_req: advance in the same cycle, no DDONE entry.
- dhit in DDONE is ignored.
- Counters update 1 cycle after the qualifying condition.

## Test plan
- Reset then ihit=1, no mem_req, no hazards, for 10 cycles -> all enables 1 each cycle, pc_en=1, stall_cnt=0, flush_cnt=0.
- mem_dren=1 with dhit cycle 2, ihit cycle 4 -> load_capture=1 in cycle 2 only; state DDONE cycles 3-4; dmem_req=0 in cycles 3-4; advance in cycle 4; stall_cnt=3.
- ex_memread=1, ex_wsel=5, id_rt=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exm_en=mwb_en=1; stall_cnt+1. Repeat with ex_wsel=0 -> no stall.
- mem_branch_taken=1 together with load_use=1, ihit=1 -> branch wins: pc_en=1, three flushes=1, flush_cnt=1, stall_cnt unchanged.
- wb_halt=1 -> halt=1 next cycle, all enables 0 thereafter regardless of ihit/dhit; nRST pulse -> halt=0, counters 0.
- Force stall_cnt to all-ones via 65 540 cycles with ihit=0 -> stall_cnt stays at 0xFFFF, no wrap.
